// File: rtl/segasys1_sndcmd_fifo.sv
// Sound-command FIFO between the main CPU block and the sound CPU.
// Queues SNDRQ/SNDNO writes and raises one timed NMI per queued byte.
module segasys1_sndcmd_fifo #(
  parameter int DEPTH_LOG2  = 2,
  parameter int NMI_LEN     = 64,
  parameter int NMI_GAP     = 16,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic                  CLK40M,
  input  logic                  RESET_N,
  input  logic                  SNDRQ,
  input  logic [7:0]            SNDNO,
  input  logic                  SCPU_CS,
  input  logic                  SCPU_RD,
  output logic [7:0]            SCPU_DO,
  output logic                  SCPU_NMI,
  output logic [DEPTH_LOG2:0]   FIFO_CNT,
  output logic                  OVF
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMAX  = (NMI_LEN > NMI_GAP)
                         ? ((NMI_LEN > ACK_TIMEOUT) ? NMI_LEN : ACK_TIMEOUT)
                         : ((NMI_GAP > ACK_TIMEOUT) ? NMI_GAP : ACK_TIMEOUT);
  localparam int TW    = $clog2(TMAX) + 1;

  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TW-1:0]       LEN_LD   = TW'(NMI_LEN - 1);
  localparam logic [TW-1:0]       GAP_LD   = TW'(NMI_GAP - 1);
  localparam logic [TW-1:0]       ACK_LD   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, GAP} st_t;

  logic [DEPTH-1:0][7:0]   mem_q;
  logic [DEPTH_LOG2-1:0]   wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]     cnt_q, cnt_d;
  logic [7:0]              do_q, do_d;
  logic                    ovf_q;
  logic                    sndrq_q, rd_q;
  st_t                     state_q, state_d;
  logic [TW-1:0]           tmr_q, tmr_d;

  logic rd, push, pop_req, empty, full, do_pop, do_push, ovf_set;

  // Push on the rising edge of SNDRQ, pop on the falling edge of the read
  // access so the byte stays stable for the whole access.
  assign rd      = SCPU_CS & SCPU_RD;
  assign push    = SNDRQ & ~sndrq_q;
  assign pop_req = rd_q & ~rd;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop_req & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push & ~do_pop)      cnt_d = cnt_q + 1'b1;
    else if (~do_push & do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Output register follows the head; holds the last byte once empty.
  always_comb begin
    do_d = do_q;
    if (!empty) do_d = mem_q[rptr_q];
  end

  always_ff @(posedge CLK40M) begin
    if (do_push) mem_q[wptr_q] <= SNDNO;
  end

  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      do_q    <= '0;
      ovf_q   <= 1'b0;
      sndrq_q <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      sndrq_q <= SNDRQ;
      rd_q    <= rd;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (ovf_set) ovf_q  <= 1'b1;
    end
  end

  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // An acknowledge (effective pop) always forces a quiet gap before the
  // next NMI; an unanswered NMI is re-raised via IDLE after the timeout.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = ASSERT;
          tmr_d   = LEN_LD;
        end
      end
      ASSERT: begin
        if (do_pop) begin
          state_d = GAP;
          tmr_d   = GAP_LD;
        end else if (tmr_q == '0) begin
          state_d = WAIT_ACK;
          tmr_d   = ACK_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (do_pop) begin
          state_d = GAP;
          tmr_d   = GAP_LD;
        end else if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    SCPU_NMI = (state_q == ASSERT);
  end

  assign SCPU_DO  = do_q;
  assign FIFO_CNT = cnt_q;
  assign OVF      = ovf_q;

endmodule
